power_spectrum_avg: RTL and testbench
=====================================

Name: power_spectrum_avg

Overview:
- Parametrised successor to the squared-periodogram stage in the front end.
- Consumes complex FFT bins (re/im) in natural order, one frame of NF bins at a time, and computes scaled power |X|^2 per bin.
- Two modes: per-frame power output, or Welch-style averaging of NAVG consecutive frames in an on-chip accumulator RAM.
- Full valid/ready handshake on both sides; feeds the mel filterbank stage downstream.

Parameters:
- DW, 16: signed width of bin_re/bin_im.
- NF, 512: bins per frame; power of two, >=4.
- LOG2_NAVG, 2: log2 of frames averaged in mode 1 (NAVG=4).
- SHIFT, 15: LSBs dropped from the raw power, by truncation.
- OW, 32: unsigned output width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- avg_mode  in  1  0 = per-frame power, 1 = NAVG-frame average
- in_valid  in  1  input bin valid
- in_ready  out  1  block can accept a bin
- bin_re  in  DW  signed real part
- bin_im  in  DW  signed imaginary part
- in_last  in  1  asserted with the last bin of a frame
- out_valid  out  1  output power valid
- out_ready  in  1  downstream accepts output
- out_power  out  OW  power value
- out_index  out  log2(NF)  bin index of out_power
- out_last  out  1  asserted with bin NF-1 output
- frame_err  out  1  one-cycle pulse on a frame-length error

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything.
  - Clears to 0: out_valid, out_power, out_index, out_last, frame_err, bin counter, frame counter, and both pipeline valid bits.
  - Accumulator RAM contents are don't-care after reset, because the first frame after reset always overwrites.
  - Reset mid-frame or mid-average abandons that frame or average; no partial output.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
- Pipeline control:
  - The pipeline advances when adv = !(out_valid && !out_ready).
  - in_ready = adv, combinational.
  - A stalled output holds out_power, out_index and out_last stable.
- Stage 1, on an accepted bin:
  - p = re*re + im*im, computed exact in 2*DW+1 unsigned bits.
  - ps = p >> SHIFT.
  - Register ps and the bin index, and issue the accumulator read for that index.
- Stage 2:
  - frame_cnt==0: acc = ps.
  - Otherwise: acc = mem[idx] + ps.
  - Write acc back to mem[idx]. The accumulator is OW+LOG2_NAVG bits wide and saturates at all-ones.
- Latency and throughput: 2 cycles from input transfer to out_valid with out_ready held high; sustained 1 bin per cycle.
- Output in mode 0: every bin produces an output, out_power = min(ps, 2^OW-1).
- Output in mode 1:
  - Output only while frame_cnt==NAVG-1, with out_power = min(acc >> LOG2_NAVG, 2^OW-1).
  - Earlier frames update the RAM only; no out_valid.
- avg_mode is sampled when bin 0 is accepted with frame_cnt==0. It stays fixed until that average (or frame, in mode 0) completes; changes mid-average are ignored.
- Counters:
  - The bin counter increments on each accepted bin and wraps NF-1 -> 0.
  - frame_cnt increments on frame completion and wraps NAVG-1 -> 0.
  - In mode 0, frame_cnt stays 0.
- Frame-length errors: in_last with bin counter != NF-1, or no in_last on the bin at NF-1.
  - The offending bin is dropped; no output for it.
  - frame_err pulses 1 cycle.
  - Bin counter and frame_cnt reset to 0, so the partial average is discarded.
  - Outputs already emitted are not recalled.
- Output sideband: out_index equals the input bin index; out_last=1 exactly when out_index==NF-1.
- No RAM hazard arises from the read-modify-write, since consecutive bins differ in index.

Test Plan:
- Mode 0, defaults, bin_re=0x4000, bin_im=0, in_last on bin 511 -> out_power=0x00002000 exactly 2 cycles later for every bin; out_last only at index 511.
- Mode 1, NAVG=4: four frames with bin_re=0x0100, 0x0200, 0x0300, 0x0400 and im=0 (ps=2, 8, 18, 32) -> no out_valid during frames 1-3; in frame 4, all 512 outputs = 15.
- Saturation override (OW=16, SHIFT=0), re=im=-32768, mode 0 -> out_power=0xFFFF.
- Backpressure: out_ready low for 5 cycles mid-frame -> in_ready low in the same cycles; out_power/out_index held; no bin lost or duplicated; index sequence continuous.
- in_last asserted at bin 100 of the second frame of an average -> frame_err one pulse, no output for that bin; the next frame restarts at index 0, and the average completes only after 4 further full frames.
- rst asserted at bin 300 of frame 3 in mode 1 -> all outputs 0 next cycle; a following mode 0 frame produces correct powers starting at index 0.

Source files
------------

// File: rtl/power_spectrum_avg.sv
// Per-bin |X|^2 power with optional NAVG-frame averaging held in an accumulator RAM.
// Two-stage pipeline: square/scale + RAM read, then accumulate/write-back + output register.
module power_spectrum_avg #(
  parameter int DW        = 16,
  parameter int NF        = 512,
  parameter int LOG2_NAVG = 2,
  parameter int SHIFT     = 15,
  parameter int OW        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  avg_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DW-1:0]  bin_re,
  input  logic signed [DW-1:0]  bin_im,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_power,
  output logic [$clog2(NF)-1:0] out_index,
  output logic                  out_last,
  output logic                  frame_err
);
  localparam int IW   = $clog2(NF);
  localparam int PW   = 2 * DW + 1;
  localparam int AW   = OW + LOG2_NAVG;
  localparam int SW   = ((PW > AW) ? PW : AW) + 1;
  localparam int FW   = (LOG2_NAVG > 0) ? LOG2_NAVG : 1;
  localparam int NAVG = 1 << LOG2_NAVG;
  localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);
  localparam logic [FW-1:0] LAST_FRM = FW'(NAVG - 1);

  logic                 adv, accept, first_bin, bin_mode, len_err, frame_done;
  logic [IW-1:0]        bin_cnt_reg;
  logic [FW-1:0]        frame_cnt_reg;
  logic                 mode_reg;
  logic signed [2*DW-1:0] re_sq, im_sq;
  logic [PW-1:0]        p_full, ps;

  logic                 s1_valid_reg, s1_first_reg, s1_emit_reg, s1_mode_reg;
  logic [PW-1:0]        s1_ps_reg;
  logic [IW-1:0]        s1_idx_reg;

  logic [AW-1:0]        mem [NF];
  logic [AW-1:0]        rd_reg;
  logic [SW-1:0]        ps_ext, sum_ext;
  logic [AW-1:0]        acc_next;
  logic [OW-1:0]        power_next;

  assign adv        = !(out_valid && !out_ready);
  assign in_ready   = adv;
  assign accept     = in_valid && adv;
  assign first_bin  = (bin_cnt_reg == '0) && (frame_cnt_reg == '0);
  // Mode is latched on the opening bin of a frame/average and held until it completes.
  assign bin_mode   = first_bin ? avg_mode : mode_reg;
  assign len_err    = in_last != (bin_cnt_reg == LAST_IDX);
  assign frame_done = in_last && (bin_cnt_reg == LAST_IDX);

  // Squares are non-negative, so their sum is exact as an unsigned PW-bit value.
  assign re_sq  = bin_re * bin_re;
  assign im_sq  = bin_im * bin_im;
  assign p_full = {1'b0, re_sq} + {1'b0, im_sq};
  assign ps     = p_full >> SHIFT;

  always_comb begin
    ps_ext   = SW'(s1_ps_reg);
    sum_ext  = s1_first_reg ? ps_ext : (ps_ext + SW'(rd_reg));
    acc_next = (sum_ext > SW'({AW{1'b1}})) ? '1 : sum_ext[AW-1:0];
    if (s1_mode_reg) begin
      power_next = acc_next[AW-1:LOG2_NAVG];
    end else begin
      power_next = (ps_ext > SW'({OW{1'b1}})) ? '1 : ps_ext[OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      mode_reg      <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_emit_reg   <= 1'b0;
      s1_mode_reg   <= 1'b0;
      s1_ps_reg     <= '0;
      s1_idx_reg    <= '0;
      out_valid     <= 1'b0;
      out_power     <= '0;
      out_index     <= '0;
      out_last      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_err <= accept && len_err;
      if (adv) begin
        s1_valid_reg <= accept && !len_err;
        if (accept) begin
          s1_ps_reg    <= ps;
          s1_idx_reg   <= bin_cnt_reg;
          s1_first_reg <= (frame_cnt_reg == '0);
          s1_mode_reg  <= bin_mode;
          s1_emit_reg  <= !bin_mode || (frame_cnt_reg == LAST_FRM);
          if (first_bin) begin
            mode_reg <= avg_mode;
          end
          // A malformed frame drops the bin and discards any partial average.
          if (len_err) begin
            bin_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
          end else if (frame_done) begin
            bin_cnt_reg   <= '0;
            frame_cnt_reg <= (!bin_mode || (frame_cnt_reg == LAST_FRM)) ? '0 : frame_cnt_reg + 1'b1;
          end else begin
            bin_cnt_reg <= bin_cnt_reg + 1'b1;
          end
        end
        out_valid <= s1_valid_reg && s1_emit_reg;
        if (s1_valid_reg && s1_emit_reg) begin
          out_power <= power_next;
          out_index <= s1_idx_reg;
          out_last  <= (s1_idx_reg == LAST_IDX);
        end
      end
    end
  end

  // Read and write indices never coincide in a cycle where the read data is used.
  always_ff @(posedge clk) begin
    if (adv && s1_valid_reg) begin
      mem[s1_idx_reg] <= acc_next;
    end
    if (accept) begin
      rd_reg <= mem[bin_cnt_reg];
    end
  end

endmodule

// File: tb/tb_power_spectrum_avg.sv
// Scoreboard bench for power_spectrum_avg: default instance plus a small saturating instance.
module tb_power_spectrum_avg;
  localparam int NF = 512;

  logic clk = 1'b0;
  logic rst, avg_mode, in_valid, in_ready, in_last, out_valid, out_ready, out_last, frame_err;
  logic signed [15:0] bin_re, bin_im;
  logic [31:0] out_power;
  logic [8:0]  out_index;

  logic s_mode, s_valid, s_ready, s_last, s_ovalid, s_oready, s_olast, s_err;
  logic signed [15:0] s_re, s_im;
  logic [15:0] s_power;
  logic [1:0]  s_index;

  always #5 clk = ~clk;

  power_spectrum_avg dut (
    .clk(clk), .rst(rst), .avg_mode(avg_mode), .in_valid(in_valid), .in_ready(in_ready),
    .bin_re(bin_re), .bin_im(bin_im), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_power(out_power), .out_index(out_index),
    .out_last(out_last), .frame_err(frame_err)
  );

  power_spectrum_avg #(.DW(16), .NF(4), .LOG2_NAVG(2), .SHIFT(0), .OW(16)) dut_sat (
    .clk(clk), .rst(rst), .avg_mode(s_mode), .in_valid(s_valid), .in_ready(s_ready),
    .bin_re(s_re), .bin_im(s_im), .in_last(s_last), .out_valid(s_ovalid),
    .out_ready(s_oready), .out_power(s_power), .out_index(s_index),
    .out_last(s_olast), .frame_err(s_err)
  );

  typedef struct {
    logic [31:0] pw;
    int          idx;
    bit          last;
    int          t;
    bit          lat;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_hi = 0;
  int s_err_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] pwr(input int re, input int im);
    longint p;
    p = longint'(re) * re + longint'(im) * im;
    return 32'(p >> 15);
  endfunction

  // Main-instance monitor: scoreboard pops on every output transfer.
  initial begin : mon_main
    exp_t e;
    bit stalled;
    logic [31:0] hp;
    logic [8:0] hi;
    stalled = 0;
    hp = '0;
    hi = '0;
    forever begin
      @(negedge clk);
      if (frame_err) err_hi++;
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_power", out_power, hp);
        check("hold_index", out_index, hi);
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        check("stall_in_ready", in_ready, 0);
        hp = out_power;
        hi = out_index;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got index %0d power %0h, required no output", out_index, out_power);
        end else begin
          e = q.pop_front();
          check("power", out_power, e.pw);
          check("index", out_index, e.idx);
          check("last", out_last, e.last);
          if (e.lat) check("latency", cyc - e.t, 2);
          $display("out idx=%0d power=%0h last=%0b", out_index, out_power, out_last);
        end
      end
    end
  end

  initial begin : mon_sat
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_err) s_err_hi++;
      if (s_ovalid && s_oready) begin
        if (sq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sat_unexpected_output: got index %0d power %0h, required no output", s_index, s_power);
        end else begin
          e = sq.pop_front();
          check("sat_power", s_power, e.pw);
          check("sat_index", s_index, e.idx);
          check("sat_last", s_olast, e.last);
          $display("sat idx=%0d power=%0h last=%0b", s_index, s_power, s_olast);
        end
      end
    end
  end

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im, input logic last,
                      input bit emit, input logic [31:0] pw, input int idx, input bit lat);
    exp_t e;
    int w;
    w = 0;
    in_valid = 1'b1;
    bin_re = re;
    bin_im = im;
    in_last = last;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, required 1", w);
    end
    if (emit) begin
      e.pw = pw; e.idx = idx; e.last = (idx == NF - 1); e.t = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic signed [15:0] re, input bit emit, input logic [31:0] pw, input bit lat);
    for (int i = 0; i < NF; i++) send(re, 16'sd0, i == NF - 1, emit, pw, i, lat);
  endtask

  task automatic ssend(input logic signed [15:0] re, input logic signed [15:0] im, input logic last,
                       input bit emit, input logic [15:0] pw, input int idx);
    exp_t e;
    s_valid = 1'b1;
    s_re = re;
    s_im = im;
    s_last = last;
    @(negedge clk);
    check("sat_in_ready", s_ready, 1);
    if (emit) begin
      e.pw = 32'(pw); e.idx = idx; e.last = (idx == 3); e.t = cyc; e.lat = 0;
      sq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int w;
    w = 0;
    in_valid = 1'b0;
    in_last = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    while ((q.size() != 0 || sq.size() != 0) && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("drain_pending", q.size() + sq.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_power"}, out_power, 0);
    check({tag, "_out_index"}, out_index, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; avg_mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; bin_re = '0; bin_im = '0;
    out_ready = 1'b1;
    s_mode = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_re = '0; s_im = '0; s_oready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_in_ready", in_ready, 1);
    check("reset_sat_valid", s_ovalid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mode 0: constant bin, 0x4000^2 >> 15 = 0x2000 on every bin, 2-cycle latency.
    avg_mode = 1'b0;
    frame(16'sh4000, 1, 32'h2000, 1);
    drain();

    // Mode 1: ps = 2, 8, 18, 32 -> (60 >> 2) = 15, only in the fourth frame.
    avg_mode = 1'b1;
    frame(16'sh0100, 0, 0, 0);
    frame(16'sh0200, 0, 0, 0);
    frame(16'sh0300, 0, 0, 0);
    frame(16'sh0400, 1, 32'd15, 1);
    drain();

    // Backpressure: 5 stalled cycles mid-frame in mode 0 with an index-dependent bin.
    avg_mode = 1'b0;
    fork
      begin
        for (int i = 0; i < NF; i++)
          send(16'(i * 8), 16'(-(i * 4)), i == NF - 1, 1, pwr(i * 8, -(i * 4)), i, 0);
      end
      begin
        repeat (200) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Early in_last at bin 100 of the second frame discards the partial average.
    err_hi = 0;
    avg_mode = 1'b1;
    frame(16'sh0100, 0, 0, 0);
    for (int i = 0; i < 100; i++) send(16'sh0200, 16'sd0, 1'b0, 0, 0, i, 0);
    send(16'sh0200, 16'sd0, 1'b1, 0, 0, 100, 0);
    frame(16'sh0100, 0, 0, 0);
    frame(16'sh0200, 0, 0, 0);
    frame(16'sh0300, 0, 0, 0);
    frame(16'sh0400, 1, 32'd15, 1);
    drain();
    check("frame_err_cycles", err_hi, 1);

    // Reset at bin 300 of the third averaged frame, then a clean mode-0 frame.
    avg_mode = 1'b1;
    frame(16'sh0100, 0, 0, 0);
    frame(16'sh0200, 0, 0, 0);
    for (int i = 0; i < 300; i++) send(16'sh0300, 16'sd0, 1'b0, 0, 0, i, 0);
    bin_re = 16'sh0300;
    in_last = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    avg_mode = 1'b0;
    for (int i = 0; i < NF; i++) send(16'sh1000, 16'sh1000, i == NF - 1, 1, 32'd1024, i, 1);
    drain();

    // Saturating instance (OW=16, SHIFT=0, NF=4).
    s_err_hi = 0;
    ssend(-16'sd32768, -16'sd32768, 1'b0, 1, 16'hFFFF, 0);
    ssend(16'sd3, 16'sd4, 1'b0, 1, 16'd25, 1);
    ssend(16'sd255, 16'sd0, 1'b0, 1, 16'hFE01, 2);
    ssend(16'sd256, 16'sd0, 1'b1, 1, 16'hFFFF, 3);
    // Missing in_last on the final bin: that bin is dropped.
    ssend(16'sd1, 16'sd0, 1'b0, 1, 16'd1, 0);
    ssend(16'sd2, 16'sd0, 1'b0, 1, 16'd4, 1);
    ssend(16'sd3, 16'sd0, 1'b0, 1, 16'd9, 2);
    ssend(16'sd4, 16'sd0, 1'b0, 0, 16'd0, 3);
    ssend(16'sd5, 16'sd0, 1'b0, 1, 16'd25, 0);
    ssend(16'sd6, 16'sd0, 1'b0, 1, 16'd36, 1);
    ssend(16'sd7, 16'sd0, 1'b0, 1, 16'd49, 2);
    ssend(16'sd8, 16'sd0, 1'b1, 1, 16'd64, 3);
    drain();
    check("sat_frame_err_cycles", s_err_hi, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
